// File: rtl/diff_logger.sv
// diff_logger: downstream checker stage for the arithmetic monitor.
// Counts checked and failing transactions with saturating counters and logs
// the earliest failing diff vectors, tagged with their transaction index, in
// a small FIFO drained through a read handshake. A non-zero ERR_LIMIT freezes
// counting and logging once that many failures have been seen.
// Optional feature macro: DIFF_LOGGER_BITCNT_EN adds o_bit_err, one
// saturating 16-bit failure counter per diff bit.
module diff_logger #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 8,
    parameter int CNT_W     = 32,
    parameter int ERR_LIMIT = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_mon_ready,
    input  logic [WIDTH-1:0]       i_diff,
    input  logic                   i_clear,
    input  logic                   i_rd_en,
    output logic                   o_rd_valid,
    output logic [CNT_W+WIDTH-1:0] o_rd_data,
    output logic                   o_empty,
    output logic                   o_full,
    output logic                   o_overflow,
    output logic [CNT_W-1:0]       o_chk_cnt,
    output logic [CNT_W-1:0]       o_err_cnt,
    output logic                   o_fail,
    output logic                   o_frozen
`ifdef DIFF_LOGGER_BITCNT_EN
    ,
    output logic [WIDTH*16-1:0]    o_bit_err
`endif
);

    localparam int                AW       = $clog2(DEPTH);
    localparam int                DW       = CNT_W + WIDTH;
    localparam logic [AW:0]       FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [CNT_W-1:0]  LIMIT_C  = CNT_W'(ERR_LIMIT);
    localparam bit                LIMIT_EN = (ERR_LIMIT != 0) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FREEZE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              sample_s;
    logic              fail_s;
    logic              hit_limit_s;
    logic              pop_s;
    logic              push_s;
    logic              ovf_set_s;

    logic [CNT_W-1:0]  chk_q, chk_d;
    logic [CNT_W-1:0]  err_q, err_d;
    logic [AW:0]       cnt_q, cnt_d;
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [DW-1:0]     mem_q [DEPTH];
    logic [DW-1:0]     rd_data_q;
    logic              rd_valid_q;
    logic              empty_q, full_q, ovf_q, fail_q, frozen_q;

    // FSM state register; reset and soft clear both return to WAIT
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            state_q <= ST_WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: follow the monitor ready flag, lock up once the limit is hit
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT: begin
                if (i_mon_ready && hit_limit_s) begin
                    state_d = ST_FREEZE;
                end else if (i_mon_ready) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_RUN: begin
                if (!i_mon_ready) begin
                    state_d = ST_WAIT;
                end else if (hit_limit_s) begin
                    state_d = ST_FREEZE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FREEZE: begin
                state_d = ST_FREEZE;
            end
            default: begin
                state_d = ST_WAIT;
            end
        endcase
    end

    // FSM outputs: a diff is sampled whenever the monitor is ready and we are not frozen
    always_comb begin
        sample_s = i_mon_ready && (state_q != ST_FREEZE);
    end

    // Counter and FIFO bookkeeping for the current cycle
    always_comb begin
        fail_s = sample_s && (i_diff != {WIDTH{1'b0}});

        if (sample_s && !(&chk_q)) begin
            chk_d = chk_q + CNT_W'(1);
        end else begin
            chk_d = chk_q;
        end

        if (fail_s && !(&err_q)) begin
            err_d = err_q + CNT_W'(1);
        end else begin
            err_d = err_q;
        end

        hit_limit_s = LIMIT_EN && fail_s && (err_d == LIMIT_C);

        // a pop frees a slot in the same cycle, so a push onto a full FIFO survives it
        pop_s     = i_rd_en && (cnt_q != '0);
        push_s    = fail_s && ((cnt_q != FULL_CNT) || pop_s);
        ovf_set_s = fail_s && !push_s;
        cnt_d     = cnt_q + (AW+1)'(push_s) - (AW+1)'(pop_s);
    end

    // Counters, FIFO pointers, read port and status flags
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            chk_q      <= {CNT_W{1'b0}};
            err_q      <= {CNT_W{1'b0}};
            cnt_q      <= {(AW+1){1'b0}};
            wr_ptr_q   <= {AW{1'b0}};
            rd_ptr_q   <= {AW{1'b0}};
            rd_data_q  <= {DW{1'b0}};
            rd_valid_q <= 1'b0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            ovf_q      <= 1'b0;
            fail_q     <= 1'b0;
            frozen_q   <= 1'b0;
        end else begin
            chk_q      <= chk_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_q  <= rd_ptr_q + AW'(1);
                rd_data_q <= mem_q[rd_ptr_q];
            end
            rd_valid_q <= pop_s;
            empty_q    <= (cnt_d == '0);
            full_q     <= (cnt_d == FULL_CNT);
            ovf_q      <= ovf_q | ovf_set_s;
            fail_q     <= fail_q | fail_s;
            frozen_q   <= (state_d == ST_FREEZE);
        end
    end

    // Log storage: entry is the pre-increment transaction index and the diff
    always_ff @(posedge clk) begin
        if (push_s && !(reset || i_clear)) begin
            mem_q[wr_ptr_q] <= {chk_q, i_diff};
        end
    end

    assign o_rd_valid = rd_valid_q;
    assign o_rd_data  = rd_data_q;
    assign o_empty    = empty_q;
    assign o_full     = full_q;
    assign o_overflow = ovf_q;
    assign o_chk_cnt  = chk_q;
    assign o_err_cnt  = err_q;
    assign o_fail     = fail_q;
    assign o_frozen   = frozen_q;

`ifdef DIFF_LOGGER_BITCNT_EN
    logic [15:0] bit_cnt_q [WIDTH];

    // Per-bit saturating tally of how often each diff bit was set in a sample
    always_ff @(posedge clk) begin
        for (int b = 0; b < WIDTH; b++) begin
            if (reset || i_clear) begin
                bit_cnt_q[b] <= 16'd0;
            end else if (sample_s && i_diff[b] && (bit_cnt_q[b] != 16'hFFFF)) begin
                bit_cnt_q[b] <= bit_cnt_q[b] + 16'd1;
            end
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit_out
        assign o_bit_err[g*16 +: 16] = bit_cnt_q[g];
    end
`endif

endmodule

// File: tb/tb_diff_logger.sv
// Self-checking bench for diff_logger. Two instances share the stimulus:
// u_a uses default parameters, u_b is small (DEPTH 4, CNT_W 4, ERR_LIMIT 3)
// so freezing and counter saturation are reachable quickly. A transaction-
// level reference model (circular arrays) tracks both.
module tb_diff_logger;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, ready, clear, rd_en;
    logic [31:0] diff;

    logic        a_rv, a_empty, a_full, a_ovf, a_fail, a_frz;
    logic [63:0] a_rd;
    logic [31:0] a_chk, a_err;
    logic        b_rv, b_empty, b_full, b_ovf, b_fail, b_frz;
    logic [35:0] b_rd;
    logic [3:0]  b_chk, b_err;
    logic [5:0]  a_flags, b_flags;
    assign a_flags = {a_rv, a_empty, a_full, a_ovf, a_fail, a_frz};
    assign b_flags = {b_rv, b_empty, b_full, b_ovf, b_fail, b_frz};
`ifdef DIFF_LOGGER_BITCNT_EN
    logic [511:0] a_bits, b_bits;
`endif

    diff_logger u_a (
        .clk(clk), .reset(reset), .i_mon_ready(ready), .i_diff(diff),
        .i_clear(clear), .i_rd_en(rd_en), .o_rd_valid(a_rv), .o_rd_data(a_rd),
        .o_empty(a_empty), .o_full(a_full), .o_overflow(a_ovf),
        .o_chk_cnt(a_chk), .o_err_cnt(a_err), .o_fail(a_fail), .o_frozen(a_frz)
`ifdef DIFF_LOGGER_BITCNT_EN
        , .o_bit_err(a_bits)
`endif
    );

    diff_logger #(.WIDTH(32), .DEPTH(4), .CNT_W(4), .ERR_LIMIT(3)) u_b (
        .clk(clk), .reset(reset), .i_mon_ready(ready), .i_diff(diff),
        .i_clear(clear), .i_rd_en(rd_en), .o_rd_valid(b_rv), .o_rd_data(b_rd),
        .o_empty(b_empty), .o_full(b_full), .o_overflow(b_ovf),
        .o_chk_cnt(b_chk), .o_err_cnt(b_err), .o_fail(b_fail), .o_frozen(b_frz)
`ifdef DIFF_LOGGER_BITCNT_EN
        , .o_bit_err(b_bits)
`endif
    );

    int n_vec = 0;
    int n_bad = 0;

    // reference model state, index 0 = u_a, 1 = u_b
    longint      m_max[2], m_lim[2];
    int          m_dep[2];
    longint      m_chk[2], m_err[2];
    bit          m_fail[2], m_ovf[2], m_frz[2], m_rv[2];
    longint      m_rd_idx[2];
    logic [31:0] m_rd_diff[2];
    longint      f_idx[2][8];
    logic [31:0] f_diff[2][8];
    int          f_head[2], f_cnt[2];
    int          m_bit[2][32];

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (reset || clear) begin
                m_chk[k] = 0; m_err[k] = 0; m_fail[k] = 0; m_ovf[k] = 0;
                m_frz[k] = 0; m_rv[k] = 0; m_rd_idx[k] = 0; m_rd_diff[k] = 32'd0;
                f_head[k] = 0; f_cnt[k] = 0;
                for (int b = 0; b < 32; b++) m_bit[k][b] = 0;
            end else begin
                m_rv[k] = 0;
                if (rd_en && f_cnt[k] > 0) begin
                    m_rv[k]      = 1;
                    m_rd_idx[k]  = f_idx[k][f_head[k]];
                    m_rd_diff[k] = f_diff[k][f_head[k]];
                    f_head[k]    = (f_head[k] + 1) % m_dep[k];
                    f_cnt[k]--;
                end
                if (ready && !m_frz[k]) begin
                    longint pre;
                    pre = m_chk[k];
                    if (m_chk[k] < m_max[k]) m_chk[k]++;
                    for (int b = 0; b < 32; b++)
                        if (diff[b] && m_bit[k][b] < 65535) m_bit[k][b]++;
                    if (diff != 32'd0) begin
                        if (m_err[k] < m_max[k]) m_err[k]++;
                        m_fail[k] = 1;
                        if (f_cnt[k] < m_dep[k]) begin
                            int t;
                            t = (f_head[k] + f_cnt[k]) % m_dep[k];
                            f_idx[k][t]  = pre;
                            f_diff[k][t] = diff;
                            f_cnt[k]++;
                        end else begin
                            m_ovf[k] = 1;
                        end
                        if (m_lim[k] != 0 && m_err[k] == m_lim[k]) m_frz[k] = 1;
                    end
                end
            end
        end
    endtask

    function automatic logic [5:0] exp_flags(int k);
        return {m_rv[k], f_cnt[k] == 0, f_cnt[k] == m_dep[k], m_ovf[k], m_fail[k], m_frz[k]};
    endfunction

`ifdef DIFF_LOGGER_BITCNT_EN
    function automatic logic [511:0] exp_bits(int k);
        logic [511:0] v;
        for (int b = 0; b < 32; b++) v[b*16 +: 16] = 16'(m_bit[k][b]);
        return v;
    endfunction
`endif

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_nz();
        logic [31:0] d;
        d = $urandom;
        if (d == 32'd0) d = 32'd1;
        return d;
    endfunction

    task automatic test_reset();
        reset = 1'b1; ready = 1'b0; clear = 1'b0; rd_en = 1'b0; diff = 32'd0;
        tick(); tick();
        reset = 1'b0;
        n_vec++; if (a_flags !== 6'b010000) begin n_bad++; $display("FAIL reset_flags_a got=%b exp=%b", a_flags, 6'b010000); end
        n_vec++; if (b_flags !== 6'b010000) begin n_bad++; $display("FAIL reset_flags_b got=%b exp=%b", b_flags, 6'b010000); end
        n_vec++; if ({a_chk, a_err, a_rd} !== 128'd0) begin n_bad++; $display("FAIL reset_cnt_a chk=%0d err=%0d rd=%h exp=0", a_chk, a_err, a_rd); end
    endtask

    task automatic test_no_fail();
        ready = 1'b1; diff = 32'd0;
        for (int i = 0; i < 10; i++) tick();
        ready = 1'b0;
        n_vec++; if (a_chk !== 32'd10 || a_err !== 32'd0) begin n_bad++; $display("FAIL nofail_cnt chk=%0d err=%0d exp=10/0", a_chk, a_err); end
        n_vec++; if (a_fail !== 1'b0 || a_empty !== 1'b1) begin n_bad++; $display("FAIL nofail_flags fail=%b empty=%b exp=0/1", a_fail, a_empty); end
    endtask

    task automatic test_single_fail();
        reset = 1'b1; tick(); reset = 1'b0;
        ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            diff = (i == 3) ? 32'h0000_0004 : 32'd0;
            tick();
        end
        ready = 1'b0; diff = 32'd0;
        n_vec++; if (a_err !== 32'd1 || a_fail !== 1'b1 || a_chk !== 32'd6) begin n_bad++; $display("FAIL single_cnt err=%0d fail=%b chk=%0d exp=1/1/6", a_err, a_fail, a_chk); end
        n_vec++; if (a_rv !== 1'b0) begin n_bad++; $display("FAIL single_pre_rv got=%b exp=0", a_rv); end
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        n_vec++; if (a_rv !== 1'b1 || a_rd !== {32'd3, 32'h4}) begin n_bad++; $display("FAIL single_read_a rv=%b data=%h exp=1/%h", a_rv, a_rd, {32'd3, 32'h4}); end
        n_vec++; if (b_rv !== 1'b1 || b_rd !== {4'd3, 32'h4}) begin n_bad++; $display("FAIL single_read_b rv=%b data=%h exp=1/%h", b_rv, b_rd, {4'd3, 32'h4}); end
        tick();
        n_vec++; if (a_rv !== 1'b0 || a_empty !== 1'b1) begin n_bad++; $display("FAIL single_after rv=%b empty=%b exp=0/1", a_rv, a_empty); end
    endtask

    task automatic test_overflow();
        logic [31:0] sent[10];
        reset = 1'b1; tick(); reset = 1'b0;
        ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            sent[i] = rand_nz(); diff = sent[i]; tick();
        end
        ready = 1'b0; diff = 32'd0;
        n_vec++; if (a_full !== 1'b1 || a_ovf !== 1'b1 || a_err !== 32'd10) begin n_bad++; $display("FAIL ovf_state full=%b ovf=%b err=%0d exp=1/1/10", a_full, a_ovf, a_err); end
        n_vec++; if (b_frz !== 1'b1 || b_err !== 4'd3 || b_chk !== 4'd3) begin n_bad++; $display("FAIL ovf_b_frozen frz=%b err=%0d chk=%0d exp=1/3/3", b_frz, b_err, b_chk); end
        rd_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_vec++; if (a_rv !== 1'b1 || a_rd !== {32'(i), sent[i]}) begin n_bad++; $display("FAIL ovf_read%0d rv=%b data=%h exp=1/%h", i, a_rv, a_rd, {32'(i), sent[i]}); end
            n_vec++; if (b_flags !== exp_flags(1)) begin n_bad++; $display("FAIL ovf_b_flags%0d got=%b exp=%b", i, b_flags, exp_flags(1)); end
        end
        n_vec++; if (a_empty !== 1'b1 || a_full !== 1'b0) begin n_bad++; $display("FAIL ovf_drained empty=%b full=%b exp=1/0", a_empty, a_full); end
        tick(); rd_en = 1'b0;
        n_vec++; if (a_rv !== 1'b0) begin n_bad++; $display("FAIL ovf_pop_empty rv=%b exp=0", a_rv); end
    endtask

    task automatic test_freeze();
        clear = 1'b1; tick(); clear = 1'b0;
        ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            diff = (i == 1 || i == 2 || i == 5 || i == 6) ? rand_nz() : 32'd0;
            tick();
            if (i == 4) begin
                n_vec++; if (b_frz !== 1'b0) begin n_bad++; $display("FAIL frz_early got=%b exp=0", b_frz); end
            end
            if (i == 5) begin
                n_vec++; if (b_frz !== 1'b1) begin n_bad++; $display("FAIL frz_assert got=%b exp=1", b_frz); end
            end
        end
        ready = 1'b0; diff = 32'd0;
        n_vec++; if (b_err !== 4'd3 || b_chk !== 4'd6 || b_ovf !== 1'b0) begin n_bad++; $display("FAIL frz_cnt err=%0d chk=%0d ovf=%b exp=3/6/0", b_err, b_chk, b_ovf); end
        n_vec++; if (a_frz !== 1'b0 || a_err !== 32'd4) begin n_bad++; $display("FAIL frz_a_unlimited frz=%b err=%0d exp=0/4", a_frz, a_err); end
        rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_vec++; if (b_rv !== (i < 3) || (i < 3 && b_rd[35:32] !== ((i == 2) ? 4'd5 : 4'(i + 1)))) begin n_bad++; $display("FAIL frz_read%0d rv=%b idx=%0d", i, b_rv, b_rd[35:32]); end
        end
        rd_en = 1'b0;
        clear = 1'b1; tick(); clear = 1'b0;
        n_vec++; if (a_flags !== 6'b010000 || b_flags !== 6'b010000) begin n_bad++; $display("FAIL clr_flags a=%b b=%b exp=010000", a_flags, b_flags); end
        n_vec++; if ({a_chk, a_err, b_chk, b_err} !== 72'd0) begin n_bad++; $display("FAIL clr_cnt a=%0d/%0d b=%0d/%0d exp=0", a_chk, a_err, b_chk, b_err); end
        ready = 1'b1; diff = rand_nz(); tick(); ready = 1'b0; diff = 32'd0;
        n_vec++; if (b_err !== 4'd1 || b_frz !== 1'b0) begin n_bad++; $display("FAIL clr_resume err=%0d frz=%b exp=1/0", b_err, b_frz); end
    endtask

    task automatic test_push_pop_full();
        reset = 1'b1; tick(); reset = 1'b0;
        ready = 1'b1;
        for (int i = 0; i < 8; i++) begin diff = rand_nz(); tick(); end
        n_vec++; if (a_full !== 1'b1 || a_ovf !== 1'b0) begin n_bad++; $display("FAIL ppf_fill full=%b ovf=%b exp=1/0", a_full, a_ovf); end
        diff = rand_nz(); rd_en = 1'b1; tick();
        n_vec++; if (a_ovf !== 1'b0 || a_full !== 1'b1 || a_rv !== 1'b1 || a_rd[63:32] !== 32'd0) begin n_bad++; $display("FAIL ppf_same ovf=%b full=%b rv=%b idx=%0d exp=0/1/1/0", a_ovf, a_full, a_rv, a_rd[63:32]); end
        ready = 1'b0; diff = 32'd0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            n_vec++; if (a_rv !== 1'b1 || a_rd[63:32] !== 32'(i) || a_rd[31:0] !== m_rd_diff[0]) begin n_bad++; $display("FAIL ppf_drain%0d rv=%b data=%h exp idx=%0d", i, a_rv, a_rd, i); end
        end
        rd_en = 1'b0;
    endtask

    task automatic test_ready_drop();
        reset = 1'b1; tick(); reset = 1'b0;
        ready = 1'b1;
        for (int i = 0; i < 5; i++) begin diff = ($urandom_range(1) != 0) ? rand_nz() : 32'd0; tick(); end
        ready = 1'b0;
        for (int i = 0; i < 4; i++) begin diff = rand_nz(); tick(); end
        n_vec++; if (a_chk !== 32'd5 || a_err !== 32'(m_err[0])) begin n_bad++; $display("FAIL drop_hold chk=%0d err=%0d exp=5/%0d", a_chk, a_err, m_err[0]); end
        ready = 1'b1; diff = 32'd0;
        for (int i = 0; i < 3; i++) tick();
        ready = 1'b0;
        n_vec++; if (a_chk !== 32'd8) begin n_bad++; $display("FAIL drop_resume chk=%0d exp=8", a_chk); end
    endtask

    task automatic test_saturation();
        clear = 1'b1; tick(); clear = 1'b0;
        ready = 1'b1; diff = 32'd0;
        for (int i = 0; i < 20; i++) tick();
        diff = rand_nz(); tick();
        ready = 1'b0; diff = 32'd0;
        n_vec++; if (b_chk !== 4'd15 || a_chk !== 32'd21) begin n_bad++; $display("FAIL sat_chk b=%0d a=%0d exp=15/21", b_chk, a_chk); end
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        n_vec++; if (b_rv !== 1'b1 || b_rd[35:32] !== 4'd15) begin n_bad++; $display("FAIL sat_idx rv=%b idx=%0d exp=1/15", b_rv, b_rd[35:32]); end
    endtask

`ifdef DIFF_LOGGER_BITCNT_EN
    task automatic test_bitcnt();
        clear = 1'b1; tick(); clear = 1'b0;
        ready = 1'b1;
        diff = 32'h1; tick();
        diff = 32'h3; tick();
        diff = 32'h1; tick();
        ready = 1'b0; diff = 32'd0;
        n_vec++; if (a_bits[15:0] !== 16'd3 || a_bits[31:16] !== 16'd1 || a_bits[511:32] !== 480'd0) begin n_bad++; $display("FAIL bitcnt b0=%0d b1=%0d exp=3/1 rest0", a_bits[15:0], a_bits[31:16]); end
    endtask
`endif

    task automatic test_random();
        clear = 1'b1; tick(); clear = 1'b0;
        for (int c = 0; c < 400; c++) begin
            ready = ($urandom_range(3) != 0);
            diff  = ($urandom_range(9) < 3) ? rand_nz() : 32'd0;
            rd_en = ($urandom_range(9) < 4);
            clear = ($urandom_range(99) == 0);
            tick();
            n_vec++; if (a_flags !== exp_flags(0)) begin n_bad++; $display("FAIL rnd_flags_a c=%0d got=%b exp=%b", c, a_flags, exp_flags(0)); end
            n_vec++; if (b_flags !== exp_flags(1)) begin n_bad++; $display("FAIL rnd_flags_b c=%0d got=%b exp=%b", c, b_flags, exp_flags(1)); end
            n_vec++; if (a_chk !== 32'(m_chk[0]) || a_err !== 32'(m_err[0])) begin n_bad++; $display("FAIL rnd_cnt_a c=%0d got=%0d/%0d exp=%0d/%0d", c, a_chk, a_err, m_chk[0], m_err[0]); end
            n_vec++; if (b_chk !== 4'(m_chk[1]) || b_err !== 4'(m_err[1])) begin n_bad++; $display("FAIL rnd_cnt_b c=%0d got=%0d/%0d exp=%0d/%0d", c, b_chk, b_err, m_chk[1], m_err[1]); end
            if (m_rv[0]) begin
                n_vec++; if (a_rd !== {32'(m_rd_idx[0]), m_rd_diff[0]}) begin n_bad++; $display("FAIL rnd_data_a c=%0d got=%h exp=%h", c, a_rd, {32'(m_rd_idx[0]), m_rd_diff[0]}); end
            end
            if (m_rv[1]) begin
                n_vec++; if (b_rd !== {4'(m_rd_idx[1]), m_rd_diff[1]}) begin n_bad++; $display("FAIL rnd_data_b c=%0d got=%h exp=%h", c, b_rd, {4'(m_rd_idx[1]), m_rd_diff[1]}); end
            end
`ifdef DIFF_LOGGER_BITCNT_EN
            n_vec++; if (a_bits !== exp_bits(0) || b_bits !== exp_bits(1)) begin n_bad++; $display("FAIL rnd_bits c=%0d", c); end
`endif
        end
        ready = 1'b0; rd_en = 1'b0; clear = 1'b0; diff = 32'd0;
    endtask

    initial begin
        m_max[0] = 64'hFFFF_FFFF; m_lim[0] = 0; m_dep[0] = 8;
        m_max[1] = 15;            m_lim[1] = 3; m_dep[1] = 4;
        test_reset();
        test_no_fail();
        test_single_fail();
        test_overflow();
        test_freeze();
        test_push_pop_full();
        test_ready_drop();
        test_saturation();
`ifdef DIFF_LOGGER_BITCNT_EN
        test_bitcnt();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
